// File: rtl/key_pad_pkg.sv
// key_pad_pkg: shared keypad constants, event record and priority-index helper.
package key_pad_pkg;
    localparam int KEY_COUNT  = 16;
    localparam int KEY_CODE_W = 4;
    localparam int ROWS       = 4;
    localparam int COLS       = 4;

    typedef struct packed {
        logic                  is_release;
        logic [KEY_CODE_W-1:0] code;
    } key_event_t;

    function automatic logic [KEY_CODE_W-1:0] lowest_set_index(input logic [KEY_COUNT-1:0] v);
        lowest_set_index = '0;
        for (int i = KEY_COUNT - 1; i >= 0; i--)
            if (v[i]) lowest_set_index = KEY_CODE_W'(i);
    endfunction
endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: show-ahead synchronous FIFO; push is refused while full even if a pop coincides.
module key_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = count == (AW + 1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/key_event_decoder.sv
// key_event_decoder: debounces 4x4 keypad snapshots and queues per-key events.
// Define KEY_RELEASE_EVENT_EN to also queue release events.
module key_event_decoder
    import key_pad_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES = 3,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLS-1:0]       keypadoutput0,
    input  logic [COLS-1:0]       keypadoutput1,
    input  logic [COLS-1:0]       keypadoutput2,
    input  logic [COLS-1:0]       keypadoutput3,
    input  logic                  available,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_release,
    input  logic                  key_ready,
    output logic [KEY_COUNT-1:0]  key_map,
    output logic                  overflow,
    input  logic                  clear_overflow
);
    logic [KEY_COUNT-1:0]  snap, candidate, press_pending, new_press, press_clr, press_left;
    logic [3:0]            count, count_nxt;
    logic [4:0]            count_inc;
    logic                  stable_upd, push_req, do_push, merge, full, empty;
    logic [KEY_CODE_W-1:0] press_idx, push_code;

    assign snap       = {keypadoutput3, keypadoutput2, keypadoutput1, keypadoutput0};
    assign count_inc  = {1'b0, count} + 5'd1;
    assign count_nxt  = snap != candidate ? 4'd1 :
                        count_inc >= 5'(DEBOUNCE_SAMPLES) ? 4'(DEBOUNCE_SAMPLES) : count_inc[3:0];
    // The candidate after this sample is always snap, so compare snap against the map.
    assign stable_upd = available && count_nxt == 4'(DEBOUNCE_SAMPLES) && snap != key_map;
    assign new_press  = stable_upd ? snap & ~key_map : '0;
    assign press_idx  = lowest_set_index(press_pending);
    assign do_push    = push_req && !full;
    assign key_valid  = !empty;

`ifdef KEY_RELEASE_EVENT_EN
    logic [KEY_COUNT-1:0]  release_pending, new_release, release_left;
    logic [KEY_CODE_W-1:0] release_idx;
    logic                  sel_release;
    key_event_t            push_ev, head;

    assign release_idx  = lowest_set_index(release_pending);
    assign sel_release  = |release_pending && (!(|press_pending) || release_idx < press_idx);
    assign push_req     = |press_pending || |release_pending;
    assign push_code    = sel_release ? release_idx : press_idx;
    assign press_clr    = do_push && !sel_release ? KEY_COUNT'(1) << push_code : '0;
    assign release_left = release_pending & ~(do_push && sel_release ? KEY_COUNT'(1) << push_code : '0);
    assign new_release  = stable_upd ? key_map & ~snap : '0;
    assign merge        = |(new_press & press_left) || |(new_release & release_left);
    assign push_ev      = '{is_release: sel_release, code: push_code};
    assign key_code     = head.code;
    assign key_release  = head.is_release;

    always_ff @(posedge clk or negedge rst)
        if (!rst) release_pending <= '0;
        else release_pending <= release_left | new_release;

    key_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(key_event_t))) u_fifo (
        .clk(clk), .rst(rst), .push(do_push), .din(push_ev), .pop(key_ready),
        .dout(head), .full(full), .empty(empty)
    );
`else
    assign push_req    = |press_pending;
    assign push_code   = press_idx;
    assign press_clr   = do_push ? KEY_COUNT'(1) << push_code : '0;
    assign merge       = |(new_press & press_left);
    assign key_release = 1'b0;

    key_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(KEY_CODE_W)) u_fifo (
        .clk(clk), .rst(rst), .push(do_push), .din(push_code), .pop(key_ready),
        .dout(key_code), .full(full), .empty(empty)
    );
`endif

    assign press_left = press_pending & ~press_clr;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            candidate     <= '0;
            count         <= '0;
            key_map       <= '0;
            press_pending <= '0;
            overflow      <= 1'b0;
        end else begin
            if (available) begin
                candidate <= snap;
                count     <= count_nxt;
            end
            if (stable_upd) key_map <= snap;
            press_pending <= press_left | new_press;
            overflow      <= merge || (overflow && !clear_overflow);
        end
endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Consumer end of the 4x4 keypad scan interface. Takes the per-scan row nibbles and the `available` strobe from the scanner.
- Debounces whole-matrix snapshots, detects newly pressed keys, and encodes each one as a 4-bit key code.
- Queues codes in a small FIFO and presents them to game/control logic on a valid/ready handshake.

Parameters:
- DEBOUNCE_SAMPLES, 3, number of consecutive identical snapshots required before the stable map updates (legal 1..15).
- FIFO_DEPTH, 4, event FIFO entries (power of 2, legal 2..16).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- keypadoutput0  in  4  row 0 column bits, 1 = pressed
- keypadoutput1  in  4  row 1 column bits
- keypadoutput2  in  4  row 2 column bits
- keypadoutput3  in  4  row 3 column bits
- available  in  1  single-cycle strobe: row inputs hold a complete new snapshot
- key_valid  out  1  FIFO head holds an event
- key_code  out  4  FIFO head key index = row*4 + col
- key_release  out  1  FIFO head is a release event (0 when feature compiled out)
- key_ready  in  1  consumer accepts the head this cycle
- key_map  out  16  debounced stable map; bit i = key i
- overflow  out  1  sticky flag: an event was merged/lost
- clear_overflow  in  1  clears overflow

Behaviour:
- Reset (async, rst=0): key_valid=0, key_code=0, key_release=0, key_map=0, overflow=0. Candidate=0, count=0, pending masks=0, FIFO empty.
- Snapshot S = {keypadoutput3, keypadoutput2, keypadoutput1, keypadoutput0}. Sampled only on clk edges where available=1; the row inputs are ignored otherwise.
- Debounce, on each sample:
  - S != candidate: candidate<=S, count<=1.
  - S == candidate: count<=min(count+1, DEBOUNCE_SAMPLES).
  - When the post-update count equals DEBOUNCE_SAMPLES and candidate differs from key_map: key_map<=candidate at that same edge, and press_pending |= candidate & ~key_map.
  - DEBOUNCE_SAMPLES=1: every sample that differs from key_map updates it immediately.
- Event push:
  - Each cycle, if a pending mask is nonzero and the FIFO is not full, push the lowest set index and clear that pending bit.
  - One push per cycle.
  - First push occurs one edge after the key_map update; key_valid rises on the following cycle boundary. Latency: sample edge E0 → push at E1 → key_valid=1 after E1.
- Pending already set: if a key's pending bit is still set when the same key is pressed again, set overflow; the event is merged, not duplicated.
- FIFO:
  - Show-ahead: key_code/key_release reflect the head whenever key_valid=1.
  - Pop on key_valid & key_ready. key_ready while empty is ignored.
  - Push is blocked when full, even if a pop occurs in the same cycle; the event waits in pending, with no loss.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow: clear_overflow and a new overflow event in the same cycle → overflow=1 (set wins).
- Simultaneous multi-key press: events emitted in ascending index order on consecutive cycles, subject to FIFO space.
- Reset mid-operation: all state cleared immediately; in-flight events discarded.

Optional Feature:
- KEY_RELEASE_EVENT_EN defined:
  - A second mask, release_pending |= key_map & ~candidate, is loaded on each stable update.
  - Push selection takes the lowest index across both masks; for the same index, press goes before release.
  - FIFO entries are 5 bits {release, code}; key_release driven from the head.
  - Overflow also set on a release merge.
- Not defined: no release mask; FIFO entries are 4 bits; key_release tied 0.

Decomposition:
- Package key_pad_pkg:
  - KEY_COUNT=16, KEY_CODE_W=4, ROWS=4, COLS=4.
  - typedef key_event_t {release, code}.
  - Function lowest_set_index(16-bit) returning a 4-bit index.
- One sub-module: key_event_fifo, a parameterised show-ahead synchronous FIFO with full/empty outputs. Debounce and push logic stay in the top.

Test Plan:
- DEBOUNCE_SAMPLES=3; keypadoutput1=4'b0100 on 3 consecutive available strobes → key_map=16'h0040 after the 3rd; one event code=6; key_valid=1 two edges after that strobe.
- Snapshots toggle 0040/0000 alternately over 6 strobes → key_map stays 0, no events.
- Keys 2, 9, 15 stabilise together, key_ready=1 → codes 2, 9, 15 on consecutive pops; key_valid drops afterwards.
- FIFO_DEPTH=4, key_ready=0, keys 0–5 stabilise → 4 entries held, pending keeps 4 and 5; raise key_ready → codes 0..5 in order, overflow=0.
- key 3 pending with FIFO full, release key 3 then press it again (debounced) → overflow=1; clear_overflow → 0; rst low mid-sequence → all outputs 0 at once.
- KEY_RELEASE_EVENT_EN: press then release key 12 → events {0,12} then {1,12}; without the macro → only {0,12}, key_release=0.
